// File: rtl/display_seq_pkg.sv
// Shared opcode and state definitions for the display init sequencer.
// Program words are {op[1:0], payload[W-1:0]}.
package display_seq_pkg;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DELAY  = 3'd4,
        ST_NEXT   = 3'd5,
        ST_STREAM = 3'd6
    } state_e;

    function automatic logic is_byte_op(input logic [1:0] op);
        return (op == OP_CMD) || (op == OP_DATA);
    endfunction

endpackage

// File: rtl/tick_delay.sv
// Loadable down-counter paced by a tick strobe.
// done pulses on the tick that brings the count to zero.
module tick_delay #(
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] value,
    input  logic          tick,
    output logic          done
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    assign done = !load && tick && (cnt_q == DW'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_seq.sv
// Runs a ROM init program of command/data/delay words, then
// streams pixel bytes from the upstream FIFO to the display stage.
module display_seq
    import display_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    output logic [AW-1:0] rom_addr,
    input  logic [W+1:0]  rom_data,
    output logic          dc,
    output logic [W-1:0]  out,
    output logic          empty,
    input  logic          get,
    input  logic [W-1:0]  pix_in,
    input  logic          pix_empty,
    output logic          pix_get,
    output logic          ready
);

    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [W-1:0]  out_q, out_d;
    logic          dc_q, dc_d;
    logic          empty_q, empty_d;

    logic [1:0]    op;
    logic [W-1:0]  payload;
    logic          dly_load;
    logic          dly_done;

    assign op      = rom_data[W+1:W];
    assign payload = rom_data[W-1:0];

    assign dly_load = (state_q == ST_DECODE) && (op == OP_DELAY)
                   && (payload != '0);

    tick_delay #(
        .DW(DW)
    ) u_tick_delay (
        .clock(clock),
        .reset(reset),
        .load (dly_load),
        .value(DW'(payload)),
        .tick (tick),
        .done (dly_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            addr_q  <= '0;
            out_q   <= '0;
            dc_q    <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            dc_q    <= dc_d;
            empty_q <= empty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        out_d   = out_q;
        dc_d    = dc_q;
        empty_d = empty_q;
        unique case (state_q)
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (is_byte_op(op)) begin
                    out_d   = payload;
                    dc_d    = (op == OP_DATA);
                    empty_d = 1'b0;
                    state_d = ST_HOLD;
                end else if (op == OP_DELAY) begin
                    state_d = (payload == '0) ? ST_NEXT : ST_DELAY;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_HOLD: begin
                if (get) begin
                    empty_d = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_DELAY: begin
                if (dly_done) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // A program that fills the ROM ends at the last word.
                if (addr_q == ADDR_LAST) begin
                    state_d = ST_STREAM;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_STREAM: state_d = ST_STREAM;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        rom_addr = addr_q;
        ready    = (state_q == ST_STREAM);
        out      = out_q;
        dc       = dc_q;
        empty    = empty_q;
        pix_get  = 1'b0;
        if (ready) begin
            out     = pix_in;
            dc      = 1'b1;
            empty   = pix_empty;
            pix_get = get && !pix_empty;
        end
    end

endmodule

// File: tb/tb_display_seq.sv
// Bench for display_seq: table vectors, directed corner sequences
// and randomized programs checked against a program-level model.
module tb_display_seq;

    localparam int W  = 8;
    localparam int AW = 6;
    localparam int DW = 16;
    localparam int NW = 1 << AW;

    localparam logic [1:0] C_CMD = 2'b00;
    localparam logic [1:0] C_DAT = 2'b01;
    localparam logic [1:0] C_DLY = 2'b10;
    localparam logic [1:0] C_END = 2'b11;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          get = 1'b0;
    logic [W-1:0]  pix_in = '0;
    logic          pix_empty = 1'b1;

    logic [AW-1:0] rom_addr;
    logic [W+1:0]  rom_data;
    logic          dc, empty, pix_get, ready;
    logic [W-1:0]  out;

    logic [1:0]    rom_addr2;
    logic [W+1:0]  rom_data2;
    logic          dc2, empty2, pix_get2, ready2;
    logic [W-1:0]  out2;

    logic [W+1:0]  rom  [NW];
    logic [W+1:0]  rom2 [4];

    logic [8:0]    got[$];
    logic [8:0]    got2[$];
    logic [8:0]    exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) rom_data  <= rom[rom_addr];
    always @(posedge clock) rom_data2 <= rom2[rom_addr2];

    display_seq #(.W(W), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .dc(dc), .out(out), .empty(empty), .get(get),
        .pix_in(pix_in), .pix_empty(pix_empty),
        .pix_get(pix_get), .ready(ready)
    );

    display_seq #(.W(W), .AW(2), .DW(DW)) dut2 (
        .clock(clock), .reset(reset), .tick(tick),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .dc(dc2), .out(out2), .empty(empty2), .get(get),
        .pix_in(pix_in), .pix_empty(pix_empty),
        .pix_get(pix_get2), .ready(ready2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_q(input string nm, input logic [8:0] a[$],
                         input logic [8:0] e[$]);
        chk({nm, "_len"}, a.size(), e.size());
        for (int i = 0; i < a.size() && i < e.size(); i++)
            chk($sformatf("%s_%0d", nm, i), a[i], e[i]);
    endtask

    task automatic step(input logic g, input logic t);
        @(negedge clock);
        get  = g;
        tick = t;
        #1;
        if (!reset) begin
            if (g && !empty && !ready) got.push_back({dc, out});
            if (g && !empty2 && !ready2) got2.push_back({dc2, out2});
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        get   = 1'b0;
        tick  = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        got.delete();
        got2.delete();
    endtask

    task automatic run_to_ready(input string nm, input int budget,
                                input int tper);
        for (int n = 0; n < budget && !ready; n++)
            step(1'b1, (tper > 0) && (n % tper == tper - 1));
        chk({nm, "_ready"}, ready, 1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < NW; i++) rom[i] = {C_END, 8'hFF};
    endtask

    // Program-level model: bytes in order, address where the program ends.
    task automatic model(output int end_addr);
        exp_q.delete();
        end_addr = NW - 1;
        for (int a = 0; a < NW; a++) begin
            if (rom[a][9:8] == C_END) begin
                end_addr = a;
                break;
            end
            if (rom[a][9:8] == C_CMD) exp_q.push_back({1'b0, rom[a][7:0]});
            if (rom[a][9:8] == C_DAT) exp_q.push_back({1'b1, rom[a][7:0]});
        end
    endtask

    typedef struct {
        logic [7:0][9:0] prog;
        int              nexp;
        logic [3:0][8:0] exp_b;
        int              end_addr;
    } vec_t;

    vec_t vt[4];

    initial begin
        int seen, tk, ea, len;
        logic stable, g, pe;
        logic [1:0] op;

        clear_rom();
        for (int i = 0; i < 4; i++) rom2[i] = {C_CMD, 8'(i + 1)};

        for (int i = 0; i < 4; i++) begin
            vt[i].prog  = '1;
            vt[i].exp_b = '0;
        end
        vt[0].prog[0] = {C_CMD, 8'hAE};
        vt[0].prog[1] = {C_DAT, 8'h3F};
        vt[0].nexp = 2;
        vt[0].exp_b[0] = 9'h0AE;
        vt[0].exp_b[1] = 9'h13F;
        vt[0].end_addr = 2;
        vt[1].prog[0] = {C_DAT, 8'h12};
        vt[1].prog[1] = {C_DLY, 8'h02};
        vt[1].prog[2] = {C_DLY, 8'h00};
        vt[1].prog[3] = {C_CMD, 8'h34};
        vt[1].nexp = 2;
        vt[1].exp_b[0] = 9'h112;
        vt[1].exp_b[1] = 9'h034;
        vt[1].end_addr = 4;
        vt[2].nexp = 0;
        vt[2].end_addr = 0;
        vt[3].prog[0] = {C_DLY, 8'h01};
        vt[3].prog[1] = {C_CMD, 8'hFF};
        vt[3].prog[2] = {C_DAT, 8'h00};
        vt[3].prog[3] = {C_DAT, 8'h80};
        vt[3].nexp = 3;
        vt[3].exp_b[0] = 9'h0FF;
        vt[3].exp_b[1] = 9'h100;
        vt[3].exp_b[2] = 9'h180;
        vt[3].end_addr = 4;

        // Reset values
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_dc", dc, 0);
        chk("rst_out", out, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_pix_get", pix_get, 0);
        chk("rst_ready", ready, 0);

        // Table-driven programs
        for (int v = 0; v < 4; v++) begin
            clear_rom();
            for (int i = 0; i < 8; i++) rom[i] = vt[v].prog[i];
            exp_q.delete();
            for (int i = 0; i < vt[v].nexp; i++)
                exp_q.push_back(vt[v].exp_b[i]);
            do_reset();
            run_to_ready($sformatf("vec%0d", v), 300, 3);
            cmp_q($sformatf("vec%0d_bytes", v), got, exp_q);
            chk($sformatf("vec%0d_addr", v), rom_addr, vt[v].end_addr);
        end
        repeat (5) step(1'b1, 1'b0);
        chk("vec_addr_parked", rom_addr, 3'd4);

        // Delay timing: ticks only start after 0x01 is taken
        clear_rom();
        rom[0] = {C_CMD, 8'h01};
        rom[1] = {C_DLY, 8'h03};
        rom[2] = {C_DLY, 8'h00};
        rom[3] = {C_CMD, 8'h29};
        do_reset();
        for (int n = 0; n < 50 && got.size() == 0; n++) step(1'b1, 1'b0);
        chk("dly_first_taken", got.size(), 1);
        seen = -1;
        tk = 0;
        for (int k = 0; k < 100 && seen < 0; k++) begin
            step(1'b1, (k % 10) == 9);
            if (!empty && out == 8'h29) seen = tk;
            if ((k % 10) == 9) tk++;
        end
        chk("dly_ticks_before_29", seen, 3);
        run_to_ready("dly", 100, 0);
        exp_q = '{9'h001, 9'h029};
        cmp_q("dly_bytes", got, exp_q);

        // Backpressure in HOLD
        clear_rom();
        rom[0] = {C_CMD, 8'h5A};
        rom[1] = {C_DAT, 8'h77};
        pix_empty = 1'b0;
        pix_in = 8'h55;
        do_reset();
        for (int n = 0; n < 20 && empty; n++) step(1'b0, 1'b0);
        chk("bp_offered", empty, 0);
        stable = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step(1'b0, 1'b0);
            if (empty || out !== 8'h5A || dc !== 1'b0 || rom_addr !== 0)
                stable = 1'b0;
        end
        chk("bp_hold_stable", stable, 1);
        step(1'b1, 1'b0);
        chk("bp_no_pix_get", pix_get, 0);
        for (int n = 0; n < 19; n++) step(1'b0, 1'b0);
        chk("bp_one_advance", got.size(), 1);
        chk("bp_next_out", out, 8'h77);
        chk("bp_next_dc", dc, 1);
        chk("bp_next_empty", empty, 0);
        run_to_ready("bp", 50, 0);
        chk("bp_total", got.size(), 2);

        // Streaming pass-through
        for (int k = 0; k < 16; k++) begin
            pe = k[0];
            g = 1'($urandom);
            pix_empty = pe;
            step(g, 1'b0);
            chk("st_out", out, 8'h55);
            chk("st_dc", dc, 1);
            chk("st_empty", empty, pe);
            chk("st_pix_get", pix_get, g & !pe);
        end
        chk("st_ready", ready, 1);
        pix_empty = 1'b0;

        // Reset during DELAY and during STREAM
        clear_rom();
        rom[0] = {C_CMD, 8'h11};
        rom[1] = {C_DLY, 8'h05};
        rom[2] = {C_CMD, 8'h22};
        do_reset();
        for (int n = 0; n < 50 && got.size() == 0; n++) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rdly_empty", empty, 1);
        chk("rdly_ready", ready, 0);
        chk("rdly_addr", rom_addr, 0);
        reset = 1'b0;
        got.delete();
        for (int n = 0; n < 50 && got.size() == 0; n++) step(1'b1, 1'b0);
        chk("rdly_restart", got.size() > 0 ? got[0] : 9'h1FF, 9'h011);
        run_to_ready("rst_run", 200, 2);
        chk("rstr_stream_empty", empty, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rstr_empty", empty, 1);
        chk("rstr_ready", ready, 0);
        chk("rstr_addr", rom_addr, 0);
        reset = 1'b0;
        got.delete();
        for (int n = 0; n < 50 && got.size() == 0; n++) step(1'b1, 1'b0);
        chk("rstr_restart", got.size() > 0 ? got[0] : 9'h1FF, 9'h011);

        // Full ROM without END on the 4-word instance
        do_reset();
        for (int n = 0; n < 60; n++) step(1'b1, 1'b0);
        exp_q = '{9'h001, 9'h002, 9'h003, 9'h004};
        cmp_q("full_bytes", got2, exp_q);
        chk("full_ready", ready2, 1);
        chk("full_addr", rom_addr2, 3);

        // Random programs against the model
        for (int r = 0; r < 8; r++) begin
            clear_rom();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                op = 2'($urandom_range(0, 2));
                if (op == C_DLY) rom[i] = {op, 8'($urandom_range(0, 3))};
                else rom[i] = {op, 8'($urandom_range(0, 255))};
            end
            model(ea);
            do_reset();
            for (int n = 0; n < 3000 && !ready; n++)
                step(1'($urandom), ($urandom % 4) == 0);
            chk($sformatf("rnd%0d_ready", r), ready, 1);
            cmp_q($sformatf("rnd%0d_bytes", r), got, exp_q);
            chk($sformatf("rnd%0d_addr", r), rom_addr, ea);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
